// File: rtl/stf_detector.sv
// Short-training-field detector: delay-16 autocorrelation with plateau FSM.
// The sample stream passes through three stages unchanged; m_axis_tuser flags
// the sample on which a plateau of PLATEAU_LEN consecutive hits completes.
module stf_detector #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned THRESH_Q4   = 12,
  parameter int unsigned ENERGY_MIN  = 4096,
  parameter int unsigned PLATEAU_LEN = 32,
  parameter int unsigned HOLDOFF_LEN = 320
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic [1:0]            state_out,
  output logic [15:0]           detect_count_out
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    PLATEAU = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic en;

  // S1: current sample and the sample 16 accepts earlier
  logic                  v1_q;
  logic [DATA_WIDTH-1:0] a1_q, b1_q;
  logic [DATA_WIDTH-1:0] hist_q [16];

  // S2: correlation and energy terms
  logic                  v2_q;
  logic [DATA_WIDTH-1:0] d2_q;
  logic signed [32:0]    re2_q, im2_q;
  logic [31:0]           e2_q;
  logic signed [32:0]    re_d, im_d, e_full;
  logic signed [32:0]    ia, qa, ib, qb;

  // S3: running sums, term history, FSM and output registers
  logic signed [32:0]    re_hist_q [16];
  logic signed [32:0]    im_hist_q [16];
  logic [31:0]           e_hist_q  [16];
  logic signed [39:0]    p_re_q, p_im_q, p_re_d, p_im_d;
  logic [39:0]           r_q, r_d;
  logic [39:0]           abs_re, abs_im;
  logic [43:0]           lhs, rhs;
  logic                  hit;
  logic [4:0]            n_q;
  logic [11:0]           cnt_q, cnt_inc;
  state_t                state_q;
  logic [15:0]           det_q;
  logic                  m_valid_q, m_user_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  assign en               = m_axis_tready || !m_valid_q;
  assign s_axis_tready    = en;
  assign m_axis_tvalid    = m_valid_q;
  assign m_axis_tdata     = m_data_q;
  assign m_axis_tuser     = m_user_q;
  assign state_out        = state_q;
  assign detect_count_out = det_q;

  // S1: accept a sample and fetch r(n-16) from the 16-deep history
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      for (int unsigned i = 0; i < 16; i++) hist_q[i] <= '0;
    end else if (en) begin
      v1_q <= s_axis_tvalid;
      if (s_axis_tvalid) begin
        a1_q      <= s_axis_tdata;
        b1_q      <= hist_q[15];
        hist_q[0] <= s_axis_tdata;
        for (int unsigned i = 1; i < 16; i++) hist_q[i] <= hist_q[i-1];
      end
    end
  end

  // S2 products: c = a*conj(b), e = |b|^2, all operands widened to 33 bits
  always_comb begin
    ia     = {{17{a1_q[15]}}, a1_q[15:0]};
    qa     = {{17{a1_q[31]}}, a1_q[31:16]};
    ib     = {{17{b1_q[15]}}, b1_q[15:0]};
    qb     = {{17{b1_q[31]}}, b1_q[31:16]};
    re_d   = ia * ib + qa * qb;
    im_d   = qa * ib - ia * qb;
    e_full = ib * ib + qb * qb;
  end

  // S2: register products alongside the raw sample
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      v2_q  <= 1'b0;
      d2_q  <= '0;
      re2_q <= '0;
      im2_q <= '0;
      e2_q  <= '0;
    end else if (en) begin
      v2_q <= v1_q;
      if (v1_q) begin
        d2_q  <= a1_q;
        re2_q <= re_d;
        im2_q <= im_d;
        e2_q  <= e_full[31:0];
      end
    end
  end

  // S3 combinational: updated window sums and the hit decision on them
  always_comb begin
    p_re_d  = p_re_q + 40'(re2_q) - 40'(re_hist_q[15]);
    p_im_d  = p_im_q + 40'(im2_q) - 40'(im_hist_q[15]);
    r_d     = r_q + {8'b0, e2_q} - {8'b0, e_hist_q[15]};
    abs_re  = p_re_d[39] ? 40'(-p_re_d) : 40'(p_re_d);
    abs_im  = p_im_d[39] ? 40'(-p_im_d) : 40'(p_im_d);
    lhs     = ({4'b0, abs_re} + {4'b0, abs_im}) << 4;
    rhs     = 44'(THRESH_Q4) * {4'b0, r_d};
    hit     = (n_q == 5'd31) && ({4'b0, r_d} >= 44'(ENERGY_MIN)) && (lhs > rhs);
    cnt_inc = cnt_q + 12'd1;
  end

  // S3: sums, detection FSM and registered stream outputs
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int unsigned i = 0; i < 16; i++) begin
        re_hist_q[i] <= '0;
        im_hist_q[i] <= '0;
        e_hist_q[i]  <= '0;
      end
      p_re_q    <= '0;
      p_im_q    <= '0;
      r_q       <= '0;
      n_q       <= '0;
      cnt_q     <= '0;
      state_q   <= SEARCH;
      det_q     <= '0;
      m_valid_q <= 1'b0;
      m_user_q  <= 1'b0;
      m_data_q  <= '0;
    end else if (en) begin
      m_valid_q <= v2_q;
      m_user_q  <= 1'b0;
      if (v2_q) begin
        m_data_q     <= d2_q;
        p_re_q       <= p_re_d;
        p_im_q       <= p_im_d;
        r_q          <= r_d;
        re_hist_q[0] <= re2_q;
        im_hist_q[0] <= im2_q;
        e_hist_q[0]  <= e2_q;
        for (int unsigned i = 1; i < 16; i++) begin
          re_hist_q[i] <= re_hist_q[i-1];
          im_hist_q[i] <= im_hist_q[i-1];
          e_hist_q[i]  <= e_hist_q[i-1];
        end
        if (n_q != 5'd31) n_q <= n_q + 5'd1;
        case (state_q)
          SEARCH: begin
            if (hit) begin
              if (PLATEAU_LEN == 1) begin
                m_user_q <= 1'b1;
                if (det_q != 16'hFFFF) det_q <= det_q + 16'd1;
                state_q  <= HOLDOFF;
                cnt_q    <= '0;
              end else begin
                state_q <= PLATEAU;
                cnt_q   <= 12'd1;
              end
            end
          end
          PLATEAU: begin
            if (!hit) begin
              state_q <= SEARCH;
              cnt_q   <= '0;
            end else if (cnt_inc == 12'(PLATEAU_LEN)) begin
              m_user_q <= 1'b1;
              if (det_q != 16'hFFFF) det_q <= det_q + 16'd1;
              state_q  <= HOLDOFF;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          HOLDOFF: begin
            if (cnt_inc == 12'(HOLDOFF_LEN)) begin
              state_q <= SEARCH;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q <= SEARCH;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

endmodule
